ycbcr422_to_rgb565: RTL and testbench

//  Reverse-path colour converter: takes a YCbCr 4:2:2 pixel stream (16-bit {Y,C}, Cb/Cr alternating)
//  and produces RGB565 plus matching vsync/hsync/de. Sits in the video pipeline after a

---
 rtl/ycbcr422_to_rgb565_pkg.sv | 37 +++
 rtl/ycbcr422_to_rgb565_if.sv | 22 ++
 rtl/ycbcr422_to_rgb565_core.sv | 67 ++++++
 rtl/ycbcr422_to_rgb565.sv | 67 ++++++
 tb/tb_ycbcr422_to_rgb565.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ycbcr422_to_rgb565_pkg.sv
// Shared video constants, pixel/sync bundles and RGB helpers for the YCbCr<->RGB converters.
// Pure declarations: no latency, no flow control.
package ycbcr422_to_rgb565_pkg;

    localparam int C_RCR      = 359;
    localparam int C_GCB      = 88;
    localparam int C_GCR      = 183;
    localparam int C_BCB      = 454;
    localparam int CHROMA_OFS = 128;
    localparam int LAT        = 4;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pix444_t;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } sync_t;

    function automatic logic [7:0] clamp8(input logic signed [11:0] v);
        if (v[11])
            return 8'd0;
        else if (v > 12'sd255)
            return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic [15:0] pack_rgb565(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/ycbcr422_to_rgb565_if.sv
// Video stream bundle: 4:2:2 YCbCr in, RGB565 out, each with vsync/hsync/de.
// No latency of its own; the stream has no backpressure.
interface ycbcr422_to_rgb565_if;
    logic        pre_frame_vsync;
    logic        pre_frame_hsync;
    logic        pre_frame_de;
    logic [15:0] pre_ycbcr;
    logic        post_frame_vsync;
    logic        post_frame_hsync;
    logic        post_frame_de;
    logic [15:0] post_rgb;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_de, pre_ycbcr,
        input  post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_de, pre_ycbcr,
        output post_frame_vsync, post_frame_hsync, post_frame_de, post_rgb
    );
endinterface

// File: rtl/ycbcr422_to_rgb565_core.sv
// BT.601 full-range 4:4:4 YCbCr -> RGB565 datapath with sync passthrough.
// Latency 3 cycles (products, round/shift, clamp/pack); never stalls.
module ycbcr422_to_rgb565_core
    import ycbcr422_to_rgb565_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  pix444_t     pix,
    input  sync_t       sync,
    output sync_t       post_sync,
    output logic [15:0] post_rgb
);

    localparam logic signed [19:0] K_RCR = 20'(C_RCR);
    localparam logic signed [19:0] K_GCB = 20'(C_GCB);
    localparam logic signed [19:0] K_GCR = 20'(C_GCR);
    localparam logic signed [19:0] K_BCB = 20'(C_BCB);
    localparam logic signed [19:0] OFS   = 20'(CHROMA_OFS);
    localparam logic signed [19:0] RND   = 20'sd128;

    logic signed [19:0] d_cb, d_cr;
    logic signed [19:0] a1_y, a1_rcr, a1_gcb, a1_gcr, a1_bcb;
    sync_t              a1_sync;
    logic signed [19:0] r_sum, g_sum, b_sum;
    logic signed [11:0] a2_r, a2_g, a2_b;
    sync_t              a2_sync;

    assign d_cb = $signed({12'd0, pix.cb}) - OFS;
    assign d_cr = $signed({12'd0, pix.cr}) - OFS;

    // 20-bit signed covers Y*256 + 454*(+/-128) + rounding with margin
    assign r_sum = a1_y + a1_rcr + RND;
    assign g_sum = a1_y - a1_gcb - a1_gcr + RND;
    assign b_sum = a1_y + a1_bcb + RND;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_y      <= '0;
            a1_rcr    <= '0;
            a1_gcb    <= '0;
            a1_gcr    <= '0;
            a1_bcb    <= '0;
            a1_sync   <= '0;
            a2_r      <= '0;
            a2_g      <= '0;
            a2_b      <= '0;
            a2_sync   <= '0;
            post_rgb  <= '0;
            post_sync <= '0;
        end else begin
            a1_y      <= $signed({4'd0, pix.y, 8'd0});
            a1_rcr    <= K_RCR * d_cr;
            a1_gcb    <= K_GCB * d_cb;
            a1_gcr    <= K_GCR * d_cr;
            a1_bcb    <= K_BCB * d_cb;
            a1_sync   <= sync;
            // taking bits [19:8] of a signed value is a floor division by 256
            a2_r      <= r_sum[19:8];
            a2_g      <= g_sum[19:8];
            a2_b      <= b_sum[19:8];
            a2_sync   <= a1_sync;
            post_rgb  <= pack_rgb565(clamp8(a2_r), clamp8(a2_g), clamp8(a2_b));
            post_sync <= a2_sync;
        end
    end

endmodule

// File: rtl/ycbcr422_to_rgb565.sv
// 4:2:2 YCbCr -> RGB565 converter: chroma pairing lookahead stage then the 4:4:4 core.
// Latency 4 cycles for pixels and syncs alike; free-running, no backpressure.
module ycbcr422_to_rgb565
    import ycbcr422_to_rgb565_pkg::*;
#(
    parameter bit         CB_FIRST  = 1'b1,
    parameter logic [7:0] NEUTRAL_C = 8'd128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ycbcr422_to_rgb565_if.slave   vif
);

    logic       ph;
    logic [7:0] l_y, l_c, hold_c;
    logic       l_ph;
    sync_t      l_sync;
    logic [7:0] pre_c, partner_c, c0, c1;
    pix444_t    pix;
    sync_t      post_sync;

    assign pre_c = vif.pre_ycbcr[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph     <= 1'b0;
            l_y    <= '0;
            l_c    <= '0;
            l_ph   <= 1'b0;
            l_sync <= '0;
            hold_c <= '0;
        end else begin
            ph     <= vif.pre_frame_de ? ~ph : 1'b0;
            l_y    <= vif.pre_ycbcr[15:8];
            l_c    <= pre_c;
            l_ph   <= vif.pre_frame_de ? ph : 1'b0;
            l_sync <= '{vsync: vif.pre_frame_vsync, hsync: vif.pre_frame_hsync,
                        de: vif.pre_frame_de};
            if (l_sync.de && !l_ph)
                hold_c <= l_c;
        end
    end

    // A phase-0 word pairs only with a phase-1 word of the same run, never across a gap
    always_comb begin
        partner_c = (vif.pre_frame_de && ph) ? pre_c : NEUTRAL_C;
        c0        = l_ph ? hold_c : l_c;
        c1        = l_ph ? l_c : partner_c;
        pix.y     = l_y;
        pix.cb    = CB_FIRST ? c0 : c1;
        pix.cr    = CB_FIRST ? c1 : c0;
    end

    ycbcr422_to_rgb565_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix       (pix),
        .sync      (l_sync),
        .post_sync (post_sync),
        .post_rgb  (vif.post_rgb)
    );

    assign vif.post_frame_vsync = post_sync.vsync;
    assign vif.post_frame_hsync = post_sync.hsync;
    assign vif.post_frame_de    = post_sync.de;

endmodule

// File: tb/tb_ycbcr422_to_rgb565.sv
// Randomised and directed bench for ycbcr422_to_rgb565 against an arithmetic reference model.
module tb_ycbcr422_to_rgb565;

    localparam int LATENCY = 4;
    localparam int MAXN    = 80;
    localparam int CN      = MAXN + LATENCY + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ycbcr422_to_rgb565_if vif ();

    ycbcr422_to_rgb565 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif)
    );

    int checks   = 0;
    int failures = 0;

    logic       s_de[MAXN], s_vs[MAXN], s_hs[MAXN];
    logic [7:0] s_y[MAXN], s_c[MAXN];
    logic        c_de[CN], c_vs[CN], c_hs[CN];
    logic [15:0] c_rgb[CN];

    task automatic drive_idle();
        vif.pre_frame_de    = 1'b0;
        vif.pre_frame_vsync = 1'b0;
        vif.pre_frame_hsync = 1'b0;
        vif.pre_ycbcr       = 16'h0000;
    endtask

    task automatic clear_seq();
        for (int i = 0; i < MAXN; i++) begin
            s_de[i] = 1'b0; s_vs[i] = 1'b0; s_hs[i] = 1'b0;
            s_y[i]  = 8'd0; s_c[i]  = 8'd0;
        end
    endtask

    // Drives n stimulus words then idles; output for word i lands in capture slot i+LATENCY.
    task automatic run_seq(input int n);
        for (int c = 0; c < n + LATENCY + 1; c++) begin
            @(posedge clk);
            #1;
            c_de[c]  = vif.post_frame_de;
            c_vs[c]  = vif.post_frame_vsync;
            c_hs[c]  = vif.post_frame_hsync;
            c_rgb[c] = vif.post_rgb;
            if (c < n) begin
                vif.pre_frame_de    = s_de[c];
                vif.pre_frame_vsync = s_vs[c];
                vif.pre_frame_hsync = s_hs[c];
                vif.pre_ycbcr       = {s_y[c], s_c[c]};
            end else begin
                drive_idle();
            end
        end
    endtask

    function automatic int floor_div256(input int x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    function automatic int clamp255(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference: position within the de run decides Cb/Cr, pairs are (even, even+1) of the run.
    function automatic logic [15:0] model_rgb(input int k, input int n);
        int s, cb, cr, y, r, g, b;
        s = k;
        while (s > 0 && s_de[s-1]) s--;
        if ((k - s) % 2 == 0) begin
            cb = s_c[k];
            cr = (k + 1 < n && s_de[k+1]) ? int'(s_c[k+1]) : 128;
        end else begin
            cb = s_c[k-1];
            cr = s_c[k];
        end
        y = s_y[k];
        r = clamp255(floor_div256(y * 256 + 359 * (cr - 128) + 128));
        g = clamp255(floor_div256(y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128));
        b = clamp255(floor_div256(y * 256 + 454 * (cb - 128) + 128));
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic test_reset();
        checks += 4;
        if (vif.post_frame_de !== 1'b0) begin
            failures++; $display("FAIL reset_de got=%b want=0", vif.post_frame_de);
        end
        if (vif.post_frame_vsync !== 1'b0) begin
            failures++; $display("FAIL reset_vsync got=%b want=0", vif.post_frame_vsync);
        end
        if (vif.post_frame_hsync !== 1'b0) begin
            failures++; $display("FAIL reset_hsync got=%b want=0", vif.post_frame_hsync);
        end
        if (vif.post_rgb !== 16'h0000) begin
            failures++; $display("FAIL reset_rgb got=%h want=0000", vif.post_rgb);
        end
    endtask

    task automatic test_gray();
        clear_seq();
        for (int i = 2; i < 10; i++) begin
            s_de[i] = 1'b1; s_y[i] = 8'd128; s_c[i] = 8'd128;
        end
        run_seq(12);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (c_de[i+LATENCY] !== s_de[i]) begin
                failures++; $display("FAIL gray_de idx=%0d got=%b want=%b", i, c_de[i+LATENCY], s_de[i]);
            end
            if (s_de[i]) begin
                checks++;
                if (c_rgb[i+LATENCY] !== 16'h8410) begin
                    failures++; $display("FAIL gray_rgb idx=%0d got=%h want=8410", i, c_rgb[i+LATENCY]);
                end
            end
        end
    endtask

    task automatic test_red();
        clear_seq();
        s_de[1] = 1'b1; s_y[1] = 8'd76; s_c[1] = 8'd85;
        s_de[2] = 1'b1; s_y[2] = 8'd76; s_c[2] = 8'd255;
        run_seq(4);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (c_rgb[i+LATENCY] !== 16'hF800 || c_de[i+LATENCY] !== 1'b1) begin
                failures++;
                $display("FAIL red_px%0d got=%h de=%b want=f800 de=1", i, c_rgb[i+LATENCY], c_de[i+LATENCY]);
            end
        end
    endtask

    task automatic test_clamp();
        clear_seq();
        s_de[1] = 1'b1; s_y[1] = 8'd255; s_c[1] = 8'd128;
        s_de[2] = 1'b1; s_y[2] = 8'd255; s_c[2] = 8'd255;
        run_seq(4);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (c_rgb[i+LATENCY] !== 16'hFD3F) begin
                failures++; $display("FAIL clamp_px%0d got=%h want=fd3f", i, c_rgb[i+LATENCY]);
            end
        end
    endtask

    task automatic test_odd_run();
        logic [15:0] exp;
        clear_seq();
        s_c[1] = 8'd200; s_c[2] = 8'd60; s_c[3] = 8'd200;
        for (int i = 1; i < 4; i++) begin
            s_de[i] = 1'b1; s_y[i] = 8'($urandom_range(0, 255));
        end
        run_seq(5);
        for (int i = 1; i < 4; i++) begin
            exp = model_rgb(i, 5);
            checks++;
            if (c_rgb[i+LATENCY] !== exp) begin
                failures++; $display("FAIL odd_px%0d got=%h want=%h", i, c_rgb[i+LATENCY], exp);
            end
        end
    endtask

    task automatic test_sync();
        clear_seq();
        s_vs[2] = 1'b1;
        s_hs[5] = 1'b1;
        s_vs[8] = 1'b1; s_hs[8] = 1'b1;
        run_seq(10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (c_vs[i+LATENCY] !== s_vs[i] || c_hs[i+LATENCY] !== s_hs[i] || c_de[i+LATENCY] !== 1'b0) begin
                failures++;
                $display("FAIL sync idx=%0d got vs=%b hs=%b de=%b want vs=%b hs=%b de=0",
                         i, c_vs[i+LATENCY], c_hs[i+LATENCY], c_de[i+LATENCY], s_vs[i], s_hs[i]);
            end
        end
    endtask

    task automatic fill_random(input int n);
        int i;
        clear_seq();
        i = 0;
        while (i < n) begin
            for (int g = $urandom_range(1, 3); g > 0 && i < n; g--) begin
                s_c[i] = 8'($urandom_range(0, 255));
                i++;
            end
            for (int r = $urandom_range(1, 9); r > 0 && i < n; r--) begin
                s_de[i] = 1'b1;
                s_y[i]  = 8'($urandom_range(0, 255));
                s_c[i]  = 8'($urandom_range(0, 255));
                i++;
            end
        end
        for (int k = 0; k < n; k++) begin
            s_vs[k] = ($urandom_range(0, 7) == 0);
            s_hs[k] = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        for (int t = 0; t < 4; t++) begin
            fill_random(60);
            run_seq(60);
            for (int i = 0; i < 60; i++) begin
                checks++;
                if (c_de[i+LATENCY] !== s_de[i] || c_vs[i+LATENCY] !== s_vs[i] || c_hs[i+LATENCY] !== s_hs[i]) begin
                    failures++;
                    $display("FAIL rand_sync t=%0d idx=%0d got=%b%b%b want=%b%b%b", t, i,
                             c_vs[i+LATENCY], c_hs[i+LATENCY], c_de[i+LATENCY], s_vs[i], s_hs[i], s_de[i]);
                end
                checks++;
                if (s_de[i]) begin
                    exp = model_rgb(i, 60);
                    if (c_rgb[i+LATENCY] !== exp) begin
                        failures++;
                        $display("FAIL rand_rgb t=%0d idx=%0d got=%h want=%h", t, i, c_rgb[i+LATENCY], exp);
                    end
                end else if ($isunknown(c_rgb[i+LATENCY])) begin
                    failures++; $display("FAIL rand_blank_x t=%0d idx=%0d got=%h want=known", t, i, c_rgb[i+LATENCY]);
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [15:0] exp;
        for (int p = 0; p < 6; p++) begin
            @(posedge clk);
            #1;
            vif.pre_frame_de = 1'b1;
            vif.pre_frame_hsync = (p == 0);
            vif.pre_ycbcr = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        drive_idle();
        checks++;
        if (vif.post_frame_de !== 1'b0 || vif.post_rgb !== 16'h0000 ||
            vif.post_frame_vsync !== 1'b0 || vif.post_frame_hsync !== 1'b0) begin
            failures++;
            $display("FAIL midrst_zero got de=%b rgb=%h vs=%b hs=%b want all 0", vif.post_frame_de,
                     vif.post_rgb, vif.post_frame_vsync, vif.post_frame_hsync);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (vif.post_frame_de !== 1'b0 || vif.post_rgb !== 16'h0000) begin
            failures++; $display("FAIL midrst_hold got de=%b rgb=%h want 0", vif.post_frame_de, vif.post_rgb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_seq();
        for (int i = 0; i < 7; i++) begin
            s_de[i] = 1'b1;
            s_y[i]  = 8'($urandom_range(0, 255));
            s_c[i]  = 8'($urandom_range(0, 255));
        end
        run_seq(9);
        for (int i = 0; i < 7; i++) begin
            exp = model_rgb(i, 9);
            checks++;
            if (c_rgb[i+LATENCY] !== exp || c_de[i+LATENCY] !== 1'b1) begin
                failures++;
                $display("FAIL midrst_line idx=%0d got=%h de=%b want=%h de=1", i, c_rgb[i+LATENCY], c_de[i+LATENCY], exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        test_gray();
        test_red();
        test_clamp();
        test_odd_run();
        test_sync();
        test_random();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
